// File: rtl/xpb_table_gen_if.sv
// Control and lookup bundle for xpb_table_gen: generation handshake,
// operand inputs and the per-channel registered lookup ports.
interface xpb_table_gen_if #(
  parameter int unsigned DATA_W = 1024,
  parameter int unsigned SEL_W  = 5,
  parameter int unsigned NUM_CH = 1
);
  logic                       start;
  logic [DATA_W-1:0]          modulus;
  logic [DATA_W-1:0]          base;
  logic                       busy;
  logic                       done;
  logic                       ready;
  logic                       err;
  logic [NUM_CH*SEL_W-1:0]    rd_sel;
  logic [NUM_CH*DATA_W-1:0]   rd_data;
  logic [NUM_CH-1:0]          rd_valid;

  modport master (
    output start, modulus, base, rd_sel,
    input  busy, done, ready, err, rd_data, rd_valid
  );

  modport slave (
    input  start, modulus, base, rd_sel,
    output busy, done, ready, err, rd_data, rd_valid
  );
endinterface

// File: rtl/xpb_table_gen.sv
// Builds entry[i] = (i*B) mod M by repeated modular addition into a register
// table, then serves NUM_CH independent 1-cycle registered lookups from it.
module xpb_table_gen #(
  parameter int unsigned DATA_W = 1024,
  parameter int unsigned SEL_W  = 5,
  parameter int unsigned NUM_CH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  xpb_table_gen_if.slave   bus
);
  localparam int unsigned DEPTH = 1 << SEL_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_GEN
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mod_q, mod_d;
  logic [DATA_W-1:0]   base_q, base_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   tbl_q [DEPTH];
  logic                wr_en;
  logic [SEL_W-1:0]    wr_addr;
  logic [DATA_W-1:0]   wr_data;

  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   next_entry;

  logic [NUM_CH*DATA_W-1:0] rd_data_q;
  logic [NUM_CH-1:0]        rd_valid_q;

  // prev_q < M and B < M, so one conditional subtract keeps the result < M
  always_comb begin
    sum        = {1'b0, prev_q} + {1'b0, base_q};
    next_entry = (sum >= {1'b0, mod_q}) ? DATA_W'(sum - {1'b0, mod_q})
                                        : sum[DATA_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    mod_d   = mod_q;
    base_d  = base_q;
    prev_d  = prev_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_addr = idx_q;
    wr_data = next_entry;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mod_d   = bus.modulus;
          base_d  = bus.base;
          ready_d = 1'b0;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((mod_q == '0) || (base_q >= mod_q)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wr_en   = 1'b1;
          wr_addr = '0;
          wr_data = '0;
          prev_d  = '0;
          idx_d   = SEL_W'(1);
          state_d = S_GEN;
        end
      end
      S_GEN: begin
        wr_en  = 1'b1;
        prev_d = next_entry;
        idx_d  = idx_q + SEL_W'(1);
        if (idx_q == '1) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mod_q   <= '0;
      base_q  <= '0;
      prev_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mod_q   <= mod_d;
      base_q  <= base_d;
      prev_q  <= prev_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Table contents are don't-care after reset, so the array has no reset
  always_ff @(posedge clk) begin
    if (wr_en) tbl_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        rd_data_q[c*DATA_W +: DATA_W] <= tbl_q[bus.rd_sel[c*SEL_W +: SEL_W]];
      end
      rd_valid_q <= {NUM_CH{ready_q}};
    end
  end

  assign bus.busy     = (state_q == S_GEN);
  assign bus.done     = done_q;
  assign bus.ready    = ready_q;
  assign bus.err      = err_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed bench for xpb_table_gen: a small 16-bit/3-bit/2-channel instance
// for the control corner cases plus a full-width instance for the sweep.
module tb_xpb_table_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xpb_table_gen_if #(.DATA_W(16), .SEL_W(3), .NUM_CH(2)) bs ();
  xpb_table_gen_if #(.DATA_W(1024), .SEL_W(5), .NUM_CH(1)) bw ();

  xpb_table_gen #(.DATA_W(16), .SEL_W(3), .NUM_CH(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bs.slave)
  );
  xpb_table_gen #(.DATA_W(1024), .SEL_W(5), .NUM_CH(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(bw.slave)
  );

  typedef struct {
    logic [2:0]  sel0;
    logic [2:0]  sel1;
    logic [15:0] exp0;
    logic [15:0] exp1;
  } vec_t;

  vec_t vec97 [8];
  vec_t vec13 [8];
  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (low 128 bits)", nm, act[127:0], exp[127:0]);
    end
  endtask

  // Leaves the bench one cycle after the start cycle T (i.e. in T+1)
  task automatic start_s(input logic [15:0] m, input logic [15:0] b);
    bs.modulus = m;
    bs.base    = b;
    bs.start   = 1'b1;
    tick();
    bs.start   = 1'b0;
  endtask

  task automatic wait_done(input bit wide, input int from, output int lat);
    lat = from;
    while (!(wide ? bw.done : bs.done) && lat < 80) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vecs(input bit use13, input string tag);
    vec_t v;
    for (int i = 0; i < 8; i++) begin
      v = use13 ? vec13[i] : vec97[i];
      bs.rd_sel = {v.sel1, v.sel0};
      tick();
      chk({tag, " ch0"}, 1024'(bs.rd_data[15:0]), 1024'(v.exp0));
      chk({tag, " ch1"}, 1024'(bs.rd_data[31:16]), 1024'(v.exp1));
      chk({tag, " valid"}, 1024'(bs.rd_valid), 1024'(2'b11));
    end
  endtask

  initial begin
    logic [15:0] t97 [8];
    logic [15:0] t13 [8];
    int lat;
    int pulses;
    bit seen;
    logic [1023:0]  wm;
    logic [1039:0]  wb;
    logic [1039:0]  we;

    t97 = '{16'd0, 16'd40, 16'd80, 16'd23, 16'd63, 16'd6, 16'd46, 16'd86};
    t13 = '{16'd0, 16'd5, 16'd10, 16'd2, 16'd7, 16'd12, 16'd4, 16'd9};
    for (int i = 0; i < 8; i++) begin
      vec97[i] = '{sel0: 3'(i), sel1: 3'(7 - i), exp0: t97[i], exp1: t97[7 - i]};
      vec13[i] = '{sel0: 3'(i), sel1: 3'(7 - i), exp0: t13[i], exp1: t13[7 - i]};
    end

    bs.start = 1'b0; bs.modulus = '0; bs.base = '0; bs.rd_sel = '0;
    bw.start = 1'b0; bw.modulus = '0; bw.base = '0; bw.rd_sel = '0;

    // Reset state
    #3;
    chk("rst busy",  1024'(bs.busy),     1024'(0));
    chk("rst done",  1024'(bs.done),     1024'(0));
    chk("rst ready", 1024'(bs.ready),    1024'(0));
    chk("rst err",   1024'(bs.err),      1024'(0));
    chk("rst valid", 1024'(bs.rd_valid), 1024'(0));
    chk("rst data",  1024'(bs.rd_data),  1024'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic generation M=97 B=40
    start_s(16'd97, 16'd40);
    chk("basic busy T+1", 1024'(bs.busy), 1024'(0));
    tick();
    chk("basic busy T+2", 1024'(bs.busy), 1024'(1));
    wait_done(1'b0, 2, lat);
    chk("basic done latency", 1024'(lat), 1024'(9));
    chk("basic ready", 1024'(bs.ready), 1024'(1));
    chk("basic busy end", 1024'(bs.busy), 1024'(0));
    tick();
    chk("basic done pulse", 1024'(bs.done), 1024'(0));
    run_vecs(1'b0, "tbl97");
    bs.rd_sel = {3'd7, 3'd3};
    tick();
    chk("sel3 ch0", 1024'(bs.rd_data[15:0]), 1024'(23));
    chk("sel7 ch1", 1024'(bs.rd_data[31:16]), 1024'(86));
    chk("sel valid", 1024'(bs.rd_valid), 1024'(2'b11));

    // Illegal base B == M
    start_s(16'd97, 16'd97);
    chk("illB ready T+1", 1024'(bs.ready), 1024'(0));
    tick();
    chk("illB err T+2", 1024'(bs.err), 1024'(1));
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bs.busy || bs.done) seen = 1'b1;
      tick();
    end
    chk("illB no busy/done", 1024'(seen), 1024'(0));
    chk("illB ready", 1024'(bs.ready), 1024'(0));
    chk("illB valid", 1024'(bs.rd_valid), 1024'(0));
    chk("illB err sticky", 1024'(bs.err), 1024'(1));

    // Illegal modulus M == 0
    start_s(16'd0, 16'd5);
    chk("M0 err cleared T+1", 1024'(bs.err), 1024'(0));
    tick();
    chk("M0 err T+2", 1024'(bs.err), 1024'(1));
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bs.busy || bs.done) seen = 1'b1;
      tick();
    end
    chk("M0 no busy/done", 1024'(seen), 1024'(0));
    chk("M0 ready", 1024'(bs.ready), 1024'(0));

    // Restart while busy: second start at T+4 is ignored
    start_s(16'd97, 16'd40);
    tick(); tick(); tick();
    bs.modulus = 16'd13; bs.base = 16'd5; bs.start = 1'b1;
    tick();
    bs.start = 1'b0;
    wait_done(1'b0, 5, lat);
    chk("restart done latency", 1024'(lat), 1024'(9));
    chk("restart err", 1024'(bs.err), 1024'(0));
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bs.done) pulses++;
    end
    chk("restart extra done", 1024'(pulses), 1024'(0));
    run_vecs(1'b0, "restart tbl97");

    // Regenerate while ready with M=13 B=5
    bs.rd_sel = {3'd1, 3'd2};
    start_s(16'd13, 16'd5);
    chk("regen ready T+1", 1024'(bs.ready), 1024'(0));
    tick();
    chk("regen valid T+2", 1024'(bs.rd_valid), 1024'(0));
    wait_done(1'b0, 2, lat);
    chk("regen done latency", 1024'(lat), 1024'(9));
    run_vecs(1'b1, "tbl13");

    // Reset mid-GEN
    start_s(16'd97, 16'd40);
    tick(); tick(); tick(); tick();
    chk("midrst busy before", 1024'(bs.busy), 1024'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst busy",  1024'(bs.busy),     1024'(0));
    chk("midrst ready", 1024'(bs.ready),    1024'(0));
    chk("midrst done",  1024'(bs.done),     1024'(0));
    chk("midrst valid", 1024'(bs.rd_valid), 1024'(0));
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("midrst idle after", 1024'(bs.busy), 1024'(0));
    start_s(16'd13, 16'd5);
    wait_done(1'b0, 1, lat);
    chk("postrst done latency", 1024'(lat), 1024'(9));
    run_vecs(1'b1, "postrst tbl13");

    // Full-width sweep, B = 2^1024 mod M for a random odd M
    for (int w = 0; w < 32; w++) wm[w*32 +: 32] = $urandom;
    wm[1023] = 1'b1;
    wm[0]    = 1'b1;
    wb = (1040'(1) << 1024) % {16'b0, wm};
    bw.modulus = wm;
    bw.base    = wb[1023:0];
    bw.start   = 1'b1;
    tick();
    bw.start   = 1'b0;
    wait_done(1'b1, 1, lat);
    chk("wide done latency", 1024'(lat), 1024'(33));
    tick();
    for (int i = 0; i < 32; i++) begin
      bw.rd_sel = 5'(i);
      tick();
      we = (1040'(i) * wb) % {16'b0, wm};
      chk($sformatf("wide entry %0d", i), bw.rd_data, we[1023:0]);
      chk($sformatf("wide entry %0d < M", i), 1024'(bw.rd_data < wm), 1024'(1));
    end
    chk("wide valid", 1024'(bw.rd_valid), 1024'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
